issue_ctrl: RTL

- Decode-to-execute issue controller. Takes one decoded instruction per cycle (register indices plus instruction class) and tracks in-flight destination registers in a scoreboard.
- Stalls decode on RAW hazards, a busy multi-cycle multiplier, an outstanding load/store, or a write-port conflict.
- Emits a registered, one-cycle issue pulse to the execute stage.
- Sits between the decoder and the ALU/MUL/LSU units.

---
 rtl/issue_pkg.sv | 38 +++
 rtl/issue_ctrl_scoreboard.sv | 83 ++++++++
 rtl/issue_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/issue_pkg.sv
// -----------------------------------------------------------------------------
// issue_pkg
// Shared definitions for the decode-to-execute issue controller:
//   - instruction-class encodings (must match the decoder's instr_type field)
//   - LSU tracking state type
//   - stall_cause bit positions
//   - default multiplier latency
//   - helper that says whether an instruction class writes a register
// -----------------------------------------------------------------------------
package issue_pkg;

    // Instruction classes as produced by the decoder
    localparam logic [2:0] ITYPE_ALU   = 3'd0;
    localparam logic [2:0] ITYPE_MUL   = 3'd1;
    localparam logic [2:0] ITYPE_LOAD  = 3'd2;
    localparam logic [2:0] ITYPE_STORE = 3'd3;
    localparam logic [2:0] ITYPE_NO_WB = 3'd4;

    // Tracking of the single outstanding memory operation
    typedef enum logic {
        LSU_IDLE = 1'b0,
        LSU_WAIT = 1'b1
    } lsu_state_t;

    // stall_cause is {hazard, struct, lsu}
    localparam int STALL_LSU_BIT    = 0;
    localparam int STALL_STRUCT_BIT = 1;
    localparam int STALL_HAZARD_BIT = 2;

    localparam int MUL_LAT_DEFAULT = 4;

    // ALU, MUL and LOAD write a destination register; STORE and NO_WB never do.
    // Unknown encodings are treated as non-writing.
    function automatic logic has_writeback(input logic [2:0] itype);
        return (itype == ITYPE_ALU) || (itype == ITYPE_MUL) || (itype == ITYPE_LOAD);
    endfunction

endpackage

// File: rtl/issue_ctrl_scoreboard.sv
// -----------------------------------------------------------------------------
// issue_ctrl_scoreboard
// Pending-write bit per architectural register. Register x0 is never tracked.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   set_en_i/set_idx_i  mark a register as pending (new writer issued)
//   clr0_en_i/_idx_i    clear from write port 0 (ALU/MUL result)
//   clr1_en_i/_idx_i    clear from write port 1 (load result)
//   rs1_idx_i/rs1_busy_o  source 1 lookup, bypassed by this cycle's clears
//   rs2_idx_i/rs2_busy_o  source 2 lookup, bypassed by this cycle's clears
//   rd_idx_i/rd_busy_o    destination lookup (WAW check), bypassed likewise
//   pending_o           current registered pending vector
// -----------------------------------------------------------------------------
module issue_ctrl_scoreboard #(
    parameter int NREGS = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set_en_i,
    input  logic [4:0]       set_idx_i,
    input  logic             clr0_en_i,
    input  logic [4:0]       clr0_idx_i,
    input  logic             clr1_en_i,
    input  logic [4:0]       clr1_idx_i,
    input  logic [4:0]       rs1_idx_i,
    input  logic [4:0]       rs2_idx_i,
    input  logic [4:0]       rd_idx_i,
    output logic             rs1_busy_o,
    output logic             rs2_busy_o,
    output logic             rd_busy_o,
    output logic [NREGS-1:0] pending_o
);

    logic [NREGS-1:0] pending_q;
    logic [NREGS-1:0] pending_d;
    logic [NREGS-1:0] clr_mask;
    logic [NREGS-1:0] set_mask;
    logic [NREGS-1:0] pending_byp;
    // Bypassed view widened to the full 5-bit index space so that lookups of
    // indices beyond NREGS read as not busy.
    logic [31:0]      byp_ext;

    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_bits
            if (gi == 0) begin : g_x0
                assign clr_mask[gi] = 1'b0;
                assign set_mask[gi] = 1'b0;
            end else begin : g_xn
                assign clr_mask[gi] = (clr0_en_i && (clr0_idx_i == 5'(gi)))
                                   || (clr1_en_i && (clr1_idx_i == 5'(gi)));
                assign set_mask[gi] = set_en_i && (set_idx_i == 5'(gi));
            end
        end

        for (genvar gi = 0; gi < 32; gi++) begin : g_ext
            if (gi < NREGS) begin : g_in
                assign byp_ext[gi] = pending_byp[gi];
            end else begin : g_out
                assign byp_ext[gi] = 1'b0;
            end
        end
    endgenerate

    // A bit cleared this cycle already counts as ready; a same-cycle set of
    // the same index wins over the clear.
    assign pending_byp = pending_q & ~clr_mask;
    assign pending_d   = pending_byp | set_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign rs1_busy_o = byp_ext[rs1_idx_i];
    assign rs2_busy_o = byp_ext[rs2_idx_i];
    assign rd_busy_o  = byp_ext[rd_idx_i];
    assign pending_o  = pending_q;

endmodule

// File: rtl/issue_ctrl.sv
// -----------------------------------------------------------------------------
// issue_ctrl
// Decode-to-execute issue controller. Accepts one decoded instruction per
// cycle, stalls on RAW/WAW hazards, a busy multiplier, a port-0 write
// collision with the multiply result, or an outstanding memory operation, and
// emits a registered one-cycle issue pulse.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   id_valid / id_ready        decode handshake (id_ready is combinational)
//   id_rs1, id_rs2, id_rd      register indices
//   id_uses_rs1, id_uses_rs2   source-read qualifiers
//   id_instr_type              instruction class (issue_pkg ITYPE_*)
//   flush                      kill the instruction in decode
//   wb0_valid / wb0_rd         ALU/MUL write port 0
//   lsu_done / lsu_rd          memory op completion, load write on port 1
//   issue_valid/_type/_rd      registered issue pulse to execute
//   stall_cause                one-hot {hazard, struct, lsu}
// -----------------------------------------------------------------------------
module issue_ctrl
    import issue_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEFAULT,
    parameter int NREGS   = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       id_valid,
    output logic       id_ready,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic [4:0] id_rd,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic [2:0] id_instr_type,
    input  logic       flush,
    input  logic       wb0_valid,
    input  logic [4:0] wb0_rd,
    input  logic       lsu_done,
    input  logic [4:0] lsu_rd,
    output logic       issue_valid,
    output logic [2:0] issue_type,
    output logic [4:0] issue_rd,
    output logic [2:0] stall_cause
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [3:0]  mul_cnt_q,     mul_cnt_d;
    lsu_state_t  lsu_state_q,   lsu_state_d;
    logic        lsu_is_load_q, lsu_is_load_d;
    logic        issue_valid_q, issue_valid_d;
    logic [2:0]  issue_type_q,  issue_type_d;
    logic [4:0]  issue_rd_q,    issue_rd_d;

    // ------------------------------------------------------------------
    // Decode of the instruction class
    // ------------------------------------------------------------------
    logic is_alu, is_mul, is_load, is_store, is_nowb;
    logic wb_en;

    assign is_alu   = (id_instr_type == ITYPE_ALU);
    assign is_mul   = (id_instr_type == ITYPE_MUL);
    assign is_load  = (id_instr_type == ITYPE_LOAD);
    assign is_store = (id_instr_type == ITYPE_STORE);
    assign is_nowb  = (id_instr_type == ITYPE_NO_WB);
    assign wb_en    = has_writeback(id_instr_type) && (id_rd != 5'd0);

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    logic             accept;
    logic             lsu_clear;
    logic             rs1_busy, rs2_busy, rd_busy;
    logic [NREGS-1:0] pending;

    // A completion only clears a register when a load is actually being
    // waited on; a stray lsu_done while idle, or a store completion, is
    // ignored.
    assign lsu_clear = lsu_done && (lsu_state_q == LSU_WAIT) && lsu_is_load_q;

    issue_ctrl_scoreboard #(
        .NREGS (NREGS)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .set_en_i   (accept && wb_en),
        .set_idx_i  (id_rd),
        .clr0_en_i  (wb0_valid),
        .clr0_idx_i (wb0_rd),
        .clr1_en_i  (lsu_clear),
        .clr1_idx_i (lsu_rd),
        .rs1_idx_i  (id_rs1),
        .rs2_idx_i  (id_rs2),
        .rd_idx_i   (id_rd),
        .rs1_busy_o (rs1_busy),
        .rs2_busy_o (rs2_busy),
        .rd_busy_o  (rd_busy),
        .pending_o  (pending)
    );

    // ------------------------------------------------------------------
    // Stall evaluation
    // ------------------------------------------------------------------
    logic stall_hazard, stall_struct, stall_lsu, stall_any;

    // WAW is folded into the hazard cause.
    assign stall_hazard = (id_uses_rs1 && rs1_busy)
                       || (id_uses_rs2 && rs2_busy)
                       || (wb_en && rd_busy);

    // With mul_cnt==2 an ALU/NO_WB issued now would reach port 0 in the same
    // cycle as the multiply result.
    assign stall_struct = (is_mul && (mul_cnt_q != 4'd0))
                       || ((is_alu || is_nowb) && (mul_cnt_q == 4'd2));

    assign stall_lsu    = (is_load || is_store) && (lsu_state_q == LSU_WAIT);

    assign stall_any    = stall_hazard || stall_struct || stall_lsu;
    assign accept       = id_valid && !flush && !stall_any;
    assign id_ready     = accept;

    // When several causes apply at once, report only the highest-priority
    // one (hazard, then struct, then lsu) so the vector stays one-hot.
    always_comb begin
        stall_cause = 3'b000;
        if (id_valid && !flush && stall_any) begin
            if (stall_hazard) begin
                stall_cause[STALL_HAZARD_BIT] = 1'b1;
            end else if (stall_struct) begin
                stall_cause[STALL_STRUCT_BIT] = 1'b1;
            end else begin
                stall_cause[STALL_LSU_BIT] = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Multiplier occupancy counter
    // ------------------------------------------------------------------
    always_comb begin
        mul_cnt_d = mul_cnt_q;
        if (accept && is_mul) begin
            mul_cnt_d = 4'(MUL_LAT);
        end else if (mul_cnt_q != 4'd0) begin
            mul_cnt_d = mul_cnt_q - 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // Outstanding memory operation
    // ------------------------------------------------------------------
    always_comb begin
        lsu_state_d   = lsu_state_q;
        lsu_is_load_d = lsu_is_load_q;
        case (lsu_state_q)
            LSU_IDLE: begin
                if (accept && (is_load || is_store)) begin
                    lsu_state_d   = LSU_WAIT;
                    lsu_is_load_d = is_load;
                end
            end
            LSU_WAIT: begin
                if (lsu_done) begin
                    lsu_state_d = LSU_IDLE;
                end
            end
            default: lsu_state_d = LSU_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Issue register; type/rd hold their last value between pulses
    // ------------------------------------------------------------------
    always_comb begin
        issue_valid_d = accept;
        issue_type_d  = issue_type_q;
        issue_rd_d    = issue_rd_q;
        if (accept) begin
            issue_type_d = id_instr_type;
            issue_rd_d   = id_rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_cnt_q     <= 4'd0;
            lsu_state_q   <= LSU_IDLE;
            lsu_is_load_q <= 1'b0;
            issue_valid_q <= 1'b0;
            issue_type_q  <= ITYPE_NO_WB;
            issue_rd_q    <= 5'd0;
        end else begin
            mul_cnt_q     <= mul_cnt_d;
            lsu_state_q   <= lsu_state_d;
            lsu_is_load_q <= lsu_is_load_d;
            issue_valid_q <= issue_valid_d;
            issue_type_q  <= issue_type_d;
            issue_rd_q    <= issue_rd_d;
        end
    end

    assign issue_valid = issue_valid_q;
    assign issue_type  = issue_type_q;
    assign issue_rd    = issue_rd_q;

    // The raw pending vector is only needed for observation in simulation.
    logic unused_pending;
    assign unused_pending = ^pending;

endmodule
